xbar_addr_router: RTL

- Single-host to three-device request router for the SoC peripheral/memory crossbar, between the CPU data port and RAM, UART and GPIO.
- Decodes each request address against the fixed address map and steers it to one device. Returns that device's response to the host.
- Tracks outstanding transactions so responses stay in order.
- Requests to unmapped addresses are answered by an internal error responder.

---
 rtl/xbar_addr_router.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/xbar_addr_router.sv
// xbar_addr_router: single-host to three-device request router.
// Decodes the host address onto RAM / UART / GPIO or an internal error
// responder. It keeps all in-flight requests on one target, so responses
// return in issue order without any reorder storage.

module xbar_addr_router #(
  parameter logic [31:0] RAM_BASE        = 32'h10000000,
  parameter logic [31:0] RAM_MASK        = 32'h000007ff,
  parameter logic [31:0] UART_BASE       = 32'h40000000,
  parameter logic [31:0] UART_MASK       = 32'h00000fff,
  parameter logic [31:0] GPIO_BASE       = 32'h40010000,
  parameter logic [31:0] GPIO_MASK       = 32'h00000fff,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_RDATA       = 32'hffffffff
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h_req_valid_i,
  output logic        h_req_ready_o,
  input  logic [31:0] h_addr_i,
  input  logic        h_we_i,
  input  logic [31:0] h_wdata_i,
  input  logic [3:0]  h_be_i,
  output logic        h_rsp_valid_o,
  input  logic        h_rsp_ready_i,
  output logic [31:0] h_rsp_rdata_o,
  output logic        h_rsp_err_o,
  output logic [2:0]  d_req_valid_o,
  input  logic [2:0]  d_req_ready_i,
  output logic [31:0] d_addr_o,
  output logic        d_we_o,
  output logic [31:0] d_wdata_o,
  output logic [3:0]  d_be_o,
  input  logic [2:0]  d_rsp_valid_i,
  output logic [2:0]  d_rsp_ready_o,
  input  logic [95:0] d_rsp_rdata_i,
  input  logic [2:0]  d_rsp_err_i
);

  // Counter width covers the full 1..15 range of MAX_OUTSTANDING.
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [1:0]    TGT_ERR  = 2'd3;

  // Address decode: first matching window wins, no match goes to the error responder.
  function automatic logic [1:0] decode_f(input logic [31:0] addr);
    logic [1:0] tgt;
    if ((addr & ~RAM_MASK) == RAM_BASE) begin
      tgt = 2'd0;
    end else if ((addr & ~UART_MASK) == UART_BASE) begin
      tgt = 2'd1;
    end else if ((addr & ~GPIO_MASK) == GPIO_BASE) begin
      tgt = 2'd2;
    end else begin
      tgt = TGT_ERR;
    end
    return tgt;
  endfunction

  // One-hot device select; the error responder has no device bit.
  function automatic logic [2:0] onehot_f(input logic [1:0] tgt);
    logic [2:0] sel;
    case (tgt)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]    steer_q, steer_d;
  logic          err_vld_q;

  logic [1:0]  tgt_s;
  logic        busy_s;
  logic        stall_s;
  logic        h_req_ready_s;
  logic [2:0]  d_req_valid_s;
  logic        h_rsp_valid_s;
  logic [31:0] h_rsp_rdata_s;
  logic        h_rsp_err_s;
  logic [2:0]  d_rsp_ready_s;
  logic [2:0]  steer_sel_s;
  logic        accept_s;
  logic        rsp_hs_s;
  logic        err_acc_s;
  logic        err_hs_s;

  // Decode and stall: a new target must wait until the previous one fully drains.
  always_comb begin
    tgt_s   = decode_f(h_addr_i);
    busy_s  = (cnt_q != CNT_ZERO);
    stall_s = (cnt_q == CNT_MAX) || (busy_s && (tgt_s != steer_q));
  end

  // Zero-latency request forwarding to the decoded device.
  always_comb begin
    h_req_ready_s = 1'b0;
    d_req_valid_s = 3'b000;
    if (rst_i) begin
      h_req_ready_s = 1'b0;
      d_req_valid_s = 3'b000;
    end else if (stall_s) begin
      h_req_ready_s = 1'b0;
      d_req_valid_s = 3'b000;
    end else if (tgt_s == TGT_ERR) begin
      h_req_ready_s = 1'b1;
      d_req_valid_s = 3'b000;
    end else begin
      h_req_ready_s = |(d_req_ready_i & onehot_f(tgt_s));
      d_req_valid_s = onehot_f(tgt_s) & {3{h_req_valid_i}};
    end
  end

  // Response return path, steered by the target of the in-flight requests.
  always_comb begin
    steer_sel_s   = onehot_f(steer_q);
    h_rsp_valid_s = 1'b0;
    h_rsp_rdata_s = 32'h00000000;
    h_rsp_err_s   = 1'b0;
    d_rsp_ready_s = 3'b000;
    if (rst_i || !busy_s) begin
      h_rsp_valid_s = 1'b0;
      h_rsp_rdata_s = 32'h00000000;
      h_rsp_err_s   = 1'b0;
      d_rsp_ready_s = 3'b000;
    end else if (steer_q == TGT_ERR) begin
      h_rsp_valid_s = err_vld_q;
      h_rsp_rdata_s = ERR_RDATA;
      h_rsp_err_s   = 1'b1;
      d_rsp_ready_s = 3'b000;
    end else begin
      h_rsp_valid_s = |(d_rsp_valid_i & steer_sel_s);
      h_rsp_err_s   = |(d_rsp_err_i & steer_sel_s);
      d_rsp_ready_s = steer_sel_s & {3{h_rsp_ready_i}};
      case (steer_q)
        2'd0:    h_rsp_rdata_s = d_rsp_rdata_i[31:0];
        2'd1:    h_rsp_rdata_s = d_rsp_rdata_i[63:32];
        2'd2:    h_rsp_rdata_s = d_rsp_rdata_i[95:64];
        default: h_rsp_rdata_s = 32'h00000000;
      endcase
    end
  end

  // Next-state for the outstanding, steer and pending-error trackers.
  always_comb begin
    accept_s  = h_req_valid_i & h_req_ready_s;
    rsp_hs_s  = h_rsp_valid_s & h_rsp_ready_i;
    err_acc_s = accept_s & (tgt_s == TGT_ERR);
    err_hs_s  = rsp_hs_s & (steer_q == TGT_ERR);
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    steer_d   = steer_q;
    case ({accept_s, rsp_hs_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    case ({err_acc_s, err_hs_s})
      2'b10:   err_cnt_d = err_cnt_q + CNT_ONE;
      2'b01:   err_cnt_d = err_cnt_q - CNT_ONE;
      default: err_cnt_d = err_cnt_q;
    endcase
    if (accept_s) begin
      steer_d = tgt_s;
    end else begin
      steer_d = steer_q;
    end
  end

  // State registers; error-response valid is registered from the pending count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= CNT_ZERO;
      err_cnt_q <= CNT_ZERO;
      steer_q   <= 2'd0;
      err_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      steer_q   <= steer_d;
      err_vld_q <= (err_cnt_d != CNT_ZERO);
    end
  end

  assign h_req_ready_o = h_req_ready_s;
  assign d_req_valid_o = d_req_valid_s;
  assign h_rsp_valid_o = h_rsp_valid_s;
  assign h_rsp_rdata_o = h_rsp_rdata_s;
  assign h_rsp_err_o   = h_rsp_err_s;
  assign d_rsp_ready_o = d_rsp_ready_s;

  // Request payload is shared by all devices and passes straight through.
  assign d_addr_o  = h_addr_i;
  assign d_we_o    = h_we_i;
  assign d_wdata_o = h_wdata_i;
  assign d_be_o    = h_be_i;

  xbar_addr_router_chk #(
    .CNT_MAX (CNT_MAX)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cnt_i         (cnt_q),
    .steer_i       (steer_q),
    .d_rsp_valid_i (d_rsp_valid_i),
    .d_rsp_ready_i (d_rsp_ready_s)
  );

endmodule

// Protocol checker for the router: flags stray device responses and
// guards the internal tracking invariants.
module xbar_addr_router_chk #(
  parameter logic [3:0] CNT_MAX = 4'd4
) (
  input logic       clk_i,
  input logic       rst_i,
  input logic [3:0] cnt_i,
  input logic [1:0] steer_i,
  input logic [2:0] d_rsp_valid_i,
  input logic [2:0] d_rsp_ready_i
);

  logic [2:0] sel_s;

  // Device currently allowed to respond, if any.
  always_comb begin
    sel_s = 3'b000;
    if (cnt_i == 4'd0) begin
      sel_s = 3'b000;
    end else begin
      case (steer_i)
        2'd0:    sel_s = 3'b001;
        2'd1:    sel_s = 3'b010;
        2'd2:    sel_s = 3'b100;
        default: sel_s = 3'b000;
      endcase
    end
  end

  a_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
    ((d_rsp_valid_i & ~sel_s) == 3'b000))
    else $warning("xbar_addr_router: response from unselected device ignored (valid=%b)", d_rsp_valid_i);

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_i <= CNT_MAX))
    else $error("xbar_addr_router: outstanding count %0d above limit", cnt_i);

  a_ready_sel : assert property (@(posedge clk_i) disable iff (rst_i)
    ((d_rsp_ready_i & ~sel_s) == 3'b000))
    else $error("xbar_addr_router: response ready to unselected device");

endmodule
